// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - decoder fields in, datapath/memory control strobes out
interface instr_sequencer_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       loadir;
  logic       loadpc;
  logic       reset_pc;
  logic       msel;
  logic       mwrite;
  logic [1:0] nsel;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       halted;

  modport master (
    input  opcode, op,
    output loadir, loadpc, reset_pc, msel, mwrite, nsel, vsel,
           write, loada, loadb, loadc, loads, asel, bsel, halted
  );

  modport slave (
    output opcode, op,
    input  loadir, loadpc, reset_pc, msel, mwrite, nsel, vsel,
           write, loada, loadb, loadc, loads, asel, bsel, halted
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle Moore control FSM for the 16-bit single-bus CPU
module instr_sequencer (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WRN, S_GA, S_GB,
    S_EX, S_EXS, S_ADR, S_MEM, S_WRD, S_WRM, S_HLT
  } state_e;

  // P_MOV covers both MOV Rd,Rm and MVN: B only, ALU A forced to zero.
  typedef enum logic [1:0] {P_MOV, P_ALU, P_CMP, P_LDR} path_e;

  typedef struct packed {
    logic       loadir;
    logic       loadpc;
    logic       reset_pc;
    logic       msel;
    logic       mwrite;
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       halted;
  } ctrl_t;

  state_e state_q, state_d;
  path_e  path_q, path_d;
  ctrl_t  ctrl_q, ctrl_d;

  function automatic ctrl_t ctrl_of(input state_e s, input path_e p);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST: begin c.loadpc = 1'b1; c.reset_pc = 1'b1; end
      S_IF1: c.msel = 1'b0;
      S_IF2: c.loadir = 1'b1;
      S_UPC: c.loadpc = 1'b1;
      S_WRN: begin c.nsel = 2'b00; c.vsel = 2'b10; c.write = 1'b1; end
      S_GA:  begin c.nsel = 2'b00; c.loada = 1'b1; end
      S_GB:  begin c.nsel = 2'b10; c.loadb = 1'b1; end
      S_EX:  begin c.loadc = 1'b1; c.asel = (p != P_ALU); end
      S_EXS: c.loads = 1'b1;
      S_ADR: begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_MEM: c.msel = 1'b1;
      S_WRD: begin c.nsel = 2'b01; c.vsel = 2'b00; c.write = 1'b1; end
      S_WRM: begin c.nsel = 2'b01; c.vsel = 2'b11; c.write = 1'b1; c.msel = 1'b1; end
      S_HLT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    case (state_q)
      S_RST: state_d = S_IF1;
      S_IF1: state_d = S_IF2;
      S_IF2: state_d = S_UPC;
      S_UPC: state_d = S_DEC;
      // Only place the decoder fields are looked at; the chosen path is latched.
      S_DEC: begin
        case ({bus.opcode, bus.op})
          5'b110_10: state_d = S_WRN;
          5'b110_00,
          5'b101_11: begin state_d = S_GB; path_d = P_MOV; end
          5'b101_00,
          5'b101_10: begin state_d = S_GA; path_d = P_ALU; end
          5'b101_01: begin state_d = S_GA; path_d = P_CMP; end
          5'b011_00: begin state_d = S_GA; path_d = P_LDR; end
          default:   state_d = S_HLT;
        endcase
      end
      S_WRN: state_d = S_IF1;
      S_GA:  state_d = (path_q == P_LDR) ? S_ADR : S_GB;
      S_GB:  state_d = (path_q == P_CMP) ? S_EXS : S_EX;
      S_EX:  state_d = S_WRD;
      S_EXS: state_d = S_IF1;
      S_ADR: state_d = S_MEM;
      S_MEM: state_d = S_WRM;
      S_WRD: state_d = S_IF1;
      S_WRM: state_d = S_IF1;
      S_HLT: state_d = S_HLT;
      default: state_d = S_HLT;
    endcase
    ctrl_d = ctrl_of(state_d, path_d);
  end

  // Outputs are registered from the next state so they change with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      path_q  <= P_MOV;
      ctrl_q  <= ctrl_of(S_RST, P_MOV);
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.loadir   = ctrl_q.loadir;
  assign bus.loadpc   = ctrl_q.loadpc;
  assign bus.reset_pc = ctrl_q.reset_pc;
  assign bus.msel     = ctrl_q.msel;
  assign bus.mwrite   = ctrl_q.mwrite;
  assign bus.nsel     = ctrl_q.nsel;
  assign bus.vsel     = ctrl_q.vsel;
  assign bus.write    = ctrl_q.write;
  assign bus.loada    = ctrl_q.loada;
  assign bus.loadb    = ctrl_q.loadb;
  assign bus.loadc    = ctrl_q.loadc;
  assign bus.loads    = ctrl_q.loads;
  assign bus.asel     = ctrl_q.asel;
  assign bus.bsel     = ctrl_q.bsel;
  assign bus.halted   = ctrl_q.halted;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the 16-bit single-bus CPU datapath. It consumes the decoded `opcode`/`op` fields from the instruction decoder and produces every datapath and memory-interface load/select strobe. It sequences fetch, PC update, decode, execute and write-back, one Moore state per cycle. It sits between the instruction decoder and the datapath/register-file/memory block, and drives `loadir`, `loadpc`, `msel`, `mwrite` plus the register-file and ALU controls.

## Interface
- No parameters. Field encodings below are fixed by the ISA.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low; forces state RST.
- `opcode` in 3: instruction[15:13] from the decoder, valid from IR.
- `op` in 2: instruction[12:11] from the decoder.
- `loadir` out 1: IR loads memory read data.
- `loadpc` out 1: PC register load enable.
- `reset_pc` out 1: PC next-value mux selects 0 (else PC+1).
- `msel` out 1: memory address select; 0 = PC, 1 = C register.
- `mwrite` out 1: memory write enable. Tied 0 in this revision.
- `nsel` out 2: register-file index select; 00 = Rn, 01 = Rd, 10 = Rm.
- `vsel` out 2: write-back source; 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
- `write` out 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: A/B/C/status register loads.
- `asel` out 1: 1 forces ALU A input to 0.
- `bsel` out 1: 1 selects sximm5 for ALU B input.
- `halted` out 1: high in state HLT.

## Operation
- Pure Moore machine. Every output is a function of the state register only. Any strobe not listed for a state is 0. `nsel`/`vsel` default to 00.
- States and outputs:
  - RST: `loadpc`, `reset_pc`.
  - IF1: `msel`=0 (memory read at PC).
  - IF2: `msel`=0, `loadir`.
  - UPC: `loadpc` (PC+1).
  - DEC: none.
  - WRN: `nsel`=00, `vsel`=10, `write`.
  - GA: `nsel`=00, `loada`.
  - GB: `nsel`=10, `loadb`.
  - EX: `loadc`, with `asel` per instruction.
  - EXS: `loads` only.
  - ADR: `bsel`, `loadc`.
  - MEM: `msel`=1.
  - WRD: `nsel`=01, `vsel`=00, `write`.
  - WRM: `nsel`=01, `vsel`=11, `write`, `msel`=1.
  - HLT: `halted`.
- Fixed fetch path: RST→IF1→IF2→UPC→DEC.
- Dispatch from DEC on {opcode,op}:
  - 110_10 MOV Rn,#imm8: WRN→IF1.
  - 110_00 MOV Rd,Rm{,sh}: GB→EX(`asel`=1)→WRD→IF1.
  - 101_00 ADD and 101_10 AND: GA→GB→EX(`asel`=0)→WRD→IF1.
  - 101_01 CMP: GA→GB→EXS→IF1. C is not loaded.
  - 101_11 MVN: GB→EX(`asel`=1)→WRD→IF1.
  - 011_00 LDR Rd,[Rn,#imm5]: GA→ADR→MEM→WRM→IF1.
  - 111_xx HALT: HLT.
  - All other encodings are illegal and go to HLT.
- The execute path taken from DEC is held in state, not re-decoded. `opcode`/`op` are sampled only in DEC, so IR changes after DEC have no effect.
- HLT is absorbing. Only `reset` low leaves it.

## Timing
- While `reset`=0, state is RST asynchronously. Outputs are `loadpc`=1, `reset_pc`=1, all others 0, so PC clears on each edge during reset.
- The first edge after reset release enters IF1.
- Cycles per instruction, counted from IF1 to the next IF1:
  - MOV imm: 5.
  - MOV reg, MVN, CMP: 7.
  - ADD, AND, LDR: 8.
- Fetch handshake: the synchronous memory returns data one cycle after the address. IF1 presents the PC address and IF2 captures it into IR. The address stays stable (`msel`=0) across both cycles.
- LDR: ADR loads C = Rn + sximm5. MEM presents C as the address. WRM writes mdata to Rd, with `msel` held at 1.
- Reset asserted mid-instruction aborts it immediately. No partial write-back occurs after the reset edge.
- `write` and `loadc` are never high together with `loadir`.

## Test plan
- Reset then fetch 0xD007 (MOV R0,#7) → `loadpc`&`reset_pc` during reset. IF1, IF2(`loadir`), UPC(`loadpc`), DEC, then WRN with `nsel`=00, `vsel`=10, `write`=1. IF1 again on cycle 6.
- Fetch 0xA140 (ADD R2,R1,R0) → GA `nsel`=00 `loada`; GB `nsel`=10 `loadb`; EX `loadc` `asel`=0; WRD `nsel`=01 `vsel`=00 `write`. 8-cycle period.
- Fetch 0xA900 (CMP R1,R0) → GA, GB, EXS with `loads`=1. `loadc`=0 and `write`=0 throughout. Back to IF1 after 7 cycles.
- Fetch 0x6162 (LDR R3,[R1,#2]) → ADR `bsel`=1 `loadc`; MEM `msel`=1; WRM `vsel`=11 `nsel`=01 `write`.
- Fetch 0xE000 and then 0x0000 (after reset) → HLT each time with `halted`=1 and all strobes 0 for 20 cycles. Pulsing `reset` low returns to RST asynchronously, without waiting for a clock edge.
- Assert `reset` low during GB of an ADD → state RST at once. No WRD `write` pulse. Normal fetch resumes after release.
